// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: lock FSM states, port indices, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LDR  = 1'b1;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_BITS_DEF  = 32;

  // Counter width that can hold the value max exactly (not just max-1).
  function automatic int lock_cnt_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_lock_ctr.sv
// Loader lock FSM plus saturating counter of loader grants taken while the core waits.
// Latency: outputs depend only on registered state and ldr_lock (no path from grants).
// Backpressure: lock_hold drops once MAX_LOCK loader grants starved the core, forcing one core grant.
module dmem_arb_lock_ctr
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ldr_lock,
  input  logic core_req,
  input  logic core_gnt,
  input  logic ldr_gnt,
  output logic locked,
  output logic lock_hold
);

  localparam int CW = lock_cnt_width(MAX_LOCK);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

  arb_state_t      state, state_nxt;
  logic [CW-1:0]   lock_cnt, cnt_nxt;

  // State and counter registers; reset drops any burst in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= cnt_nxt;
    end
  end

  // Next state: enter on a locked loader grant, leave as soon as the loader releases lock.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = lock_cnt;
    case (state)
      ARB_IDLE: begin
        if (ldr_gnt && ldr_lock) state_nxt = ARB_LOCKED;
      end
      ARB_LOCKED: begin
        if (!ldr_lock) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase

    if ((state == ARB_LOCKED) && !ldr_lock) begin
      cnt_nxt = '0;
    end else if (core_gnt) begin
      cnt_nxt = '0;
    end else if ((state == ARB_LOCKED) && ldr_gnt && core_req && (lock_cnt < CNT_MAX)) begin
      cnt_nxt = lock_cnt + 1'b1;
    end
  end

  assign locked    = (state == ARB_LOCKED);
  assign lock_hold = ldr_lock && (lock_cnt < CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data RAM between the core load/store port and the loader/DMA port (optional DMEM_ARB_LOCK_EN).
// Latency: grants combinational, core access in grant cycle, loader read data one cycle after grant.
// Backpressure: the losing port is denied (core_stall); locked loader bursts yield after MAX_LOCK starved cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int data_width   = DATA_WIDTH_DEF,
  parameter int address_bits = ADDR_BITS_DEF,
  parameter int MAX_LOCK     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_req,
  input  logic                    core_we,
  input  logic [address_bits-1:0] core_addr,
  input  logic [data_width-1:0]   core_wdata,
  output logic                    core_gnt,
  output logic                    core_stall,
  output logic [data_width-1:0]   core_rdata,
  input  logic                    ldr_req,
  input  logic                    ldr_we,
  input  logic                    ldr_lock,
  input  logic [address_bits-1:0] ldr_addr,
  input  logic [data_width-1:0]   ldr_wdata,
  output logic                    ldr_gnt,
  output logic                    ldr_rvalid,
  output logic [data_width-1:0]   ldr_rdata,
  output logic [address_bits-1:0] ram_addr,
  output logic [data_width-1:0]   ram_wd,
  output logic                    ram_we,
  input  logic [data_width-1:0]   ram_rd
);

  logic last;      // port granted most recently
  logic ldr_wins;  // loader takes a contended cycle

`ifdef DMEM_ARB_LOCK_EN
  logic locked;
  logic lock_hold;

  dmem_arb_lock_ctr #(
    .MAX_LOCK (MAX_LOCK)
  ) u_lock_ctr (
    .clk       (clk),
    .rst       (rst),
    .ldr_lock  (ldr_lock),
    .core_req  (core_req),
    .core_gnt  (core_gnt),
    .ldr_gnt   (ldr_gnt),
    .locked    (locked),
    .lock_hold (lock_hold)
  );

  // In a burst the loader keeps priority only while it holds lock and has budget left.
  assign ldr_wins = locked ? lock_hold : (last == PORT_CORE);
`else
  logic unused_cfg;
  assign unused_cfg = ldr_lock ^ (MAX_LOCK > 0);
  assign ldr_wins   = (last == PORT_CORE);
`endif

  assign core_gnt   = core_req & ~(ldr_req & ldr_wins);
  assign ldr_gnt    = ldr_req & ~(core_req & ~ldr_wins);
  assign core_stall = core_req & ~core_gnt;
  assign core_rdata = ram_rd;

  // Round-robin history; reset favours the core on the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= PORT_LDR;
    end else if (core_gnt) begin
      last <= PORT_CORE;
    end else if (ldr_gnt) begin
      last <= PORT_LDR;
    end
  end

  // Capture loader read data at the end of its grant cycle; writes never produce rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldr_rvalid <= 1'b0;
      ldr_rdata  <= '0;
    end else begin
      ldr_rvalid <= ldr_gnt & ~ldr_we;
      if (ldr_gnt && !ldr_we) ldr_rdata <= ram_rd;
    end
  end

  // RAM port mux: idle cycles drive zeros so nothing is written.
  always_comb begin
    ram_addr = '0;
    ram_wd   = '0;
    ram_we   = 1'b0;
    if (core_gnt) begin
      ram_addr = core_addr;
      ram_wd   = core_wdata;
      ram_we   = core_we;
    end else if (ldr_gnt) begin
      ram_addr = ldr_addr;
      ram_wd   = ldr_wdata;
      ram_we   = ldr_we;
    end
  end

endmodule
